// File: rtl/mux_chip_nto1_rr_if.sv
// Bundle of the N-to-1 mux producer and consumer handshakes plus mode/select controls.
// The master modport drives the inputs; the mux itself is the slave.
interface mux_chip_nto1_rr_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
);
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output mode, sel, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid
    );

    modport slave (
        input  mode, sel, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid
    );
endinterface

// File: rtl/mux_chip_nto1_rr.sv
// N-to-1 W-bit channel mux with a single-entry registered output, fixed-select or
// round-robin grant, and valid/ready handshakes on every port.
module mux_chip_nto1_rr #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS)
) (
    input logic               clk,
    input logic               rst_n,
    mux_chip_nto1_rr_if.slave io_bus
);
    logic                r_out_valid;
    logic [WIDTH-1:0]    r_out_data;
    logic [SEL_W-1:0]    r_out_chan;
    logic [SEL_W-1:0]    r_ptr;

    logic                w_can_accept;
    logic                w_gnt_vld;
    logic [SEL_W-1:0]    w_gnt;
    logic [WIDTH-1:0]    w_gnt_data;
    logic [CHANNELS-1:0] w_in_ready;
    logic                w_xfer;

    // Channel index ptr+k modulo CHANNELS; k never exceeds CHANNELS so one subtraction suffices.
    function automatic logic [SEL_W-1:0] rr_idx(input logic [SEL_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= CHANNELS) s = s - CHANNELS;
        return SEL_W'(s);
    endfunction

    assign w_can_accept = !r_out_valid || io_bus.out_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        if (!io_bus.mode) begin
            // An out-of-range select matches no channel, so it yields no grant.
            for (int i = 0; i < CHANNELS; i++) begin
                if (io_bus.sel == SEL_W'(i) && io_bus.in_valid[i]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = SEL_W'(i);
                end
            end
        end else begin
            for (int k = 1; k <= CHANNELS; k++) begin
                if (!w_gnt_vld && io_bus.in_valid[rr_idx(r_ptr, k)]) begin
                    w_gnt_vld = 1'b1;
                    w_gnt     = rr_idx(r_ptr, k);
                end
            end
        end
    end

    always_comb begin
        w_gnt_data = '0;
        w_in_ready = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (w_gnt == SEL_W'(i)) begin
                w_gnt_data    = io_bus.in_data[i*WIDTH +: WIDTH];
                w_in_ready[i] = w_gnt_vld && w_can_accept;
            end
        end
    end

    assign w_xfer = w_gnt_vld && w_can_accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_ptr       <= SEL_W'(CHANNELS - 1);
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_gnt_data;
            r_out_chan  <= w_gnt;
            if (io_bus.mode) r_ptr <= w_gnt;
        end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign io_bus.in_ready  = w_in_ready;
    assign io_bus.out_data  = r_out_data;
    assign io_bus.out_chan  = r_out_chan;
    assign io_bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_mux_chip_nto1_rr.sv
// Bench for mux_chip_nto1_rr: vector table and hand sequences on a 4x8 instance and a 3x8
// instance, then randomized traffic against a behavioural model of the grant rules.
module tb_mux_chip_nto1_rr;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mux_chip_nto1_rr_if #(.WIDTH(8), .CHANNELS(4)) bus_a ();
    mux_chip_nto1_rr_if #(.WIDTH(8), .CHANNELS(3)) bus_b ();

    mux_chip_nto1_rr #(.WIDTH(8), .CHANNELS(4)) u_dut_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_a.slave)
    );

    mux_chip_nto1_rr #(.WIDTH(8), .CHANNELS(3)) u_dut_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] vld;
        logic       ordy;
        logic [3:0] exp_rdy;
        logic       exp_vld;
        logic [7:0] exp_data;
        logic [1:0] exp_chan;
    } vec_t;

    vec_t tbl[23];

    // Behavioural model state for the random phase.
    logic       m_valid;
    logic [7:0] m_data;
    int         m_chan;
    int         m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Called at posedge+1: drive inputs, check in_ready, cross the edge, check outputs.
    task automatic step_a(input vec_t v);
        bus_a.mode      = v.mode;
        bus_a.sel       = v.sel;
        bus_a.in_valid  = v.vld;
        bus_a.out_ready = v.ordy;
        #1;
        chk("a_in_ready", 32'(bus_a.in_ready), 32'(v.exp_rdy));
        @(posedge clk);
        #1;
        chk("a_out_valid", 32'(bus_a.out_valid), 32'(v.exp_vld));
        chk("a_out_data", 32'(bus_a.out_data), 32'(v.exp_data));
        chk("a_out_chan", 32'(bus_a.out_chan), 32'(v.exp_chan));
    endtask

    task automatic step_b(input logic md, input logic [1:0] s, input logic [2:0] vld,
                          input logic [2:0] exp_rdy, input logic exp_vld,
                          input logic [7:0] exp_data, input logic [1:0] exp_chan);
        bus_b.mode      = md;
        bus_b.sel       = s;
        bus_b.in_valid  = vld;
        bus_b.out_ready = 1'b1;
        #1;
        chk("b_in_ready", 32'(bus_b.in_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        chk("b_out_valid", 32'(bus_b.out_valid), 32'(exp_vld));
        chk("b_out_data", 32'(bus_b.out_data), 32'(exp_data));
        chk("b_out_chan", 32'(bus_b.out_chan), 32'(exp_chan));
    endtask

    // Winner by the grant rules: fixed index, or first requester after ptr going round.
    function automatic int model_grant(input logic md, input int s, input logic [3:0] v,
                                       input int p);
        if (!md) return (s < 4 && v[s]) ? s : -1;
        for (int k = 1; k <= 4; k++) begin
            if (v[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    initial begin
        vec_t v;
        int   g;
        checks = 0;
        errors = 0;

        bus_a.mode = 1'b0; bus_a.sel = '0; bus_a.in_valid = '0; bus_a.out_ready = 1'b1;
        bus_a.in_data = {8'h44, 8'h33, 8'h22, 8'h11};
        bus_b.mode = 1'b0; bus_b.sel = '0; bus_b.in_valid = '0; bus_b.out_ready = 1'b1;
        bus_b.in_data = {8'hC3, 8'hB2, 8'hA1};

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("rst_out_data", 32'(bus_a.out_data), 32'd0);
        chk("rst_out_chan", 32'(bus_a.out_chan), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed select sweep.
        for (int i = 0; i < 4; i++)
            tbl[i] = '{1'b0, 2'(i), 4'hF, 1'b1, 4'(1 << i), 1'b1, 8'(17 * (i + 1)), 2'(i)};
        // Round-robin fairness from ptr reset value.
        for (int i = 0; i < 8; i++)
            tbl[4 + i] = '{1'b1, 2'd0, 4'hF, 1'b1, 4'(1 << (i % 4)), 1'b1,
                           8'(17 * (i % 4 + 1)), 2'(i % 4)};
        // Sparse requests on 1 and 3 with ptr at 3, then lone channel 0.
        tbl[12] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[13] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[14] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[15] = '{1'b1, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
        tbl[16] = '{1'b1, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
        // Backpressure on a held 0x22, then drain-and-reload, then drain to empty.
        tbl[17] = '{1'b0, 2'd1, 4'hF, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
        tbl[18] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[19] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[20] = '{1'b0, 2'd1, 4'hF, 1'b0, 4'b0000, 1'b1, 8'h22, 2'd1};
        tbl[21] = '{1'b0, 2'd2, 4'hF, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
        tbl[22] = '{1'b0, 2'd2, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h33, 2'd2};

        for (int i = 0; i < 23; i++) step_a(tbl[i]);

        // Reset while FULL with ptr moved away from its reset value.
        step_a('{1'b1, 2'd0, 4'b0010, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1});
        bus_a.in_valid  = '0;
        bus_a.out_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(bus_a.out_valid), 32'd0);
        chk("midrst_out_data", 32'(bus_a.out_data), 32'd0);
        chk("midrst_out_chan", 32'(bus_a.out_chan), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step_a('{1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0});
        step_a('{1'b0, 2'd0, 4'h0, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0});

        // Three-channel instance: out-of-range select, then resume round-robin from ptr 0.
        step_b(1'b1, 2'd0, 3'b111, 3'b001, 1'b1, 8'hA1, 2'd0);
        step_b(1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 8'hA1, 2'd0);
        step_b(1'b0, 2'd3, 3'b111, 3'b000, 1'b0, 8'hA1, 2'd0);
        step_b(1'b1, 2'd3, 3'b111, 3'b010, 1'b1, 8'hB2, 2'd1);
        step_b(1'b1, 2'd3, 3'b111, 3'b100, 1'b1, 8'hC3, 2'd2);
        step_b(1'b1, 2'd3, 3'b111, 3'b001, 1'b1, 8'hA1, 2'd0);
        bus_b.in_valid = '0;

        // Randomized traffic against the model.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 3;
        for (int n = 0; n < 400; n++) begin
            bus_a.mode      = 1'($urandom_range(0, 1));
            bus_a.sel       = 2'($urandom_range(0, 3));
            bus_a.in_valid  = 4'($urandom);
            bus_a.out_ready = ($urandom_range(0, 3) != 0);
            bus_a.in_data   = $urandom;
            #1;
            g = model_grant(bus_a.mode, int'(bus_a.sel), bus_a.in_valid, m_ptr);
            if (g >= 0 && (!m_valid || bus_a.out_ready))
                chk("rnd_in_ready", 32'(bus_a.in_ready), 32'(1 << g));
            else
                chk("rnd_in_ready", 32'(bus_a.in_ready), 32'd0);
            @(posedge clk);
            if (g >= 0 && (!m_valid || bus_a.out_ready)) begin
                m_valid = 1'b1;
                m_data  = bus_a.in_data[g*8 +: 8];
                m_chan  = g;
                if (bus_a.mode) m_ptr = g;
            end else if (bus_a.out_ready) begin
                m_valid = 1'b0;
            end
            #1;
            chk("rnd_out_valid", 32'(bus_a.out_valid), 32'(m_valid));
            chk("rnd_out_data", 32'(bus_a.out_data), 32'(m_data));
            chk("rnd_out_chan", 32'(bus_a.out_chan), 32'(m_chan));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
